irq_source: RTL and testbench

Interrupt source controller feeding the 16-bit `interrupts` pulse bus that the control-register file ORs into ISR (cr2). It synchronizes asynchronous device IRQ lines and applies per-line edge/level mode and enable mask. It also runs a reload timer on one line, then emits single-cycle request pulses. Software configures it through a small memory-mapped register port. ISR clearing, IMR gating and exception entry stay in the control-register file.

---
 rtl/irq_source_if.sv | 9 +
 rtl/irq_source.sv | 74 +++++++
 tb/tb_irq_source.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/irq_source_if.sv
// irq_source_if: memory-mapped configuration port of irq_source
interface irq_source_if;
  logic        cfg_wen;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  modport master(output cfg_wen, cfg_addr, cfg_wdata, input cfg_rdata);
  modport slave(input cfg_wen, cfg_addr, cfg_wdata, output cfg_rdata);
endinterface

// File: rtl/irq_source.sv
// irq_source: synchronizes IRQ lines, applies edge/level mode, mask and a reload timer, emits one-cycle pulses
module irq_source #(
  parameter int NUM_IRQ      = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int LEVEL_REPEAT = 64,
  parameter int TIMER_IRQ    = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_en,
  input  logic [NUM_IRQ-1:0] irq_in,
  irq_source_if.slave        cfg,
  output logic [15:0]        interrupts
);
  localparam int CW = $clog2(LEVEL_REPEAT);
  logic [NUM_IRQ-1:0] r_sync [SYNC_STAGES];
  logic [NUM_IRQ-1:0] r_sp, r_mode, r_mask, r_mask_d, r_int;
  logic [CW-1:0]      r_rep [NUM_IRQ];
  logic [31:0]        r_reload, r_count, r_rdata;
  logic [NUM_IRQ-1:0] w_s, w_rise, w_hit, w_req;
  logic [31:0]        w_count_nx, w_rdata;
  logic               w_tick, w_wr_mode, w_wr_mask, w_wr_reload, w_wr_count;
  assign w_s         = r_sync[SYNC_STAGES-1];
  assign w_wr_mode   = cfg.cfg_wen && cfg.cfg_addr == 2'd0;
  assign w_wr_mask   = cfg.cfg_wen && cfg.cfg_addr == 2'd1;
  assign w_wr_reload = cfg.cfg_wen && cfg.cfg_addr == 2'd2;
  assign w_wr_count  = cfg.cfg_wen && cfg.cfg_addr == 2'd3;
  assign w_tick      = clk_en && r_count == 32'd1;
  // an unmask while the line is high restarts the level train like a fresh rising edge
  assign w_rise = w_s & (~r_sp | ~r_mask_d);
  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_hit
    assign w_hit[i] = r_rep[i] == CW'(LEVEL_REPEAT - 1);
  end
  assign w_req = ((w_s & ~r_sp & r_mode) | (w_s & ~r_mode & (w_rise | w_hit)) |
                  (NUM_IRQ'(w_tick) << TIMER_IRQ)) & r_mask;
  assign w_count_nx = w_wr_reload ? cfg.cfg_wdata
                    : r_reload == 32'd0 ? 32'd0
                    : w_wr_count ? cfg.cfg_wdata
                    : clk_en && r_count != 32'd0 ? (w_tick ? r_reload : r_count - 32'd1)
                    : r_count;
  assign w_rdata = cfg.cfg_addr == 2'd0 ? 32'(r_mode)
                 : cfg.cfg_addr == 2'd1 ? 32'(r_mask)
                 : cfg.cfg_addr == 2'd2 ? r_reload
                 : r_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
      for (int k = 0; k < NUM_IRQ; k++) r_rep[k] <= '0;
      r_sp     <= '0;
      r_mode   <= '0;
      r_mask   <= '0;
      r_mask_d <= '0;
      r_int    <= '0;
      r_reload <= '0;
      r_count  <= '0;
      r_rdata  <= '0;
    end else begin
      r_sync[0] <= irq_in;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      for (int k = 0; k < NUM_IRQ; k++)
        r_rep[k] <= (!w_s[k] || !r_mask[k] || w_rise[k] || w_hit[k]) ? '0 : r_rep[k] + 1'b1;
      r_sp     <= w_s;
      r_mask_d <= r_mask;
      r_int    <= w_req & ~r_int;
      r_count  <= w_count_nx;
      r_rdata  <= w_rdata;
      if (w_wr_mode) r_mode <= cfg.cfg_wdata[NUM_IRQ-1:0];
      if (w_wr_mask) r_mask <= cfg.cfg_wdata[NUM_IRQ-1:0];
      if (w_wr_reload) r_reload <= cfg.cfg_wdata;
    end
  end
  assign cfg.cfg_rdata = r_rdata;
  assign interrupts    = 16'(r_int);
endmodule

// File: tb/tb_irq_source.sv
// tb_irq_source: directed and randomized checks of irq_source against a cycle-level reference model
module tb_irq_source;
  localparam int N = 16, SS = 2, LR = 64;
  logic clk = 1'b0, rst_n = 1'b1, clk_en = 1'b0;
  logic [N-1:0] irq_in = '0;
  logic [15:0] interrupts;
  int n_chk = 0, n_fail = 0;
  irq_source_if cfg();
  irq_source #(.NUM_IRQ(N), .SYNC_STAGES(SS), .LEVEL_REPEAT(LR), .TIMER_IRQ(0)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .irq_in(irq_in), .cfg(cfg), .interrupts(interrupts)
  );
  always #5 clk = ~clk;
  logic [N-1:0] m_q [$];
  logic [N-1:0] m_s, m_sp, m_mode, m_mask, m_maskp, m_int;
  logic [31:0]  m_reload, m_count, m_rdata;
  int m_start [N];
  int cyc;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic m_reset();
    m_q = {};
    for (int k = 0; k < SS; k++) m_q.push_back('0);
    m_s = '0; m_sp = '0; m_mode = '0; m_mask = '0; m_maskp = '0; m_int = '0;
    m_reload = 0; m_count = 0; m_rdata = 0; cyc = 0;
    for (int i = 0; i < N; i++) m_start[i] = -1;
  endtask
  task automatic m_step();
    logic [N-1:0] req;
    logic tick;
    logic [1:0] a;
    logic [31:0] d;
    tick = clk_en && m_count == 1;
    a = cfg.cfg_addr;
    d = cfg.cfg_wdata;
    for (int i = 0; i < N; i++) begin
      if (!m_s[i] || !m_mask[i]) m_start[i] = -1;
      else if (!m_sp[i] || !m_maskp[i]) m_start[i] = cyc;
      req[i] = m_mask[i] && (m_mode[i] ? (m_s[i] && !m_sp[i])
                                       : (m_start[i] >= 0 && (cyc - m_start[i]) % LR == 0));
    end
    req[0] = req[0] | (m_mask[0] && tick);
    m_int = req & ~m_int;
    m_rdata = a == 0 ? 32'(m_mode) : a == 1 ? 32'(m_mask) : a == 2 ? m_reload : m_count;
    m_maskp = m_mask;
    if (cfg.cfg_wen && a == 2) begin m_reload = d; m_count = d; end
    else if (m_reload == 0) m_count = 0;
    else if (cfg.cfg_wen && a == 3) m_count = d;
    else if (clk_en && m_count != 0) m_count = tick ? m_reload : m_count - 1;
    if (cfg.cfg_wen && a == 0) m_mode = d[N-1:0];
    if (cfg.cfg_wen && a == 1) m_mask = d[N-1:0];
    m_sp = m_s;
    m_q.push_back(irq_in);
    void'(m_q.pop_front());
    m_s = m_q[0];
    cyc++;
  endtask
  task automatic step();
    @(posedge clk);
    if (rst_n) m_step();
    #1;
    check("int", interrupts, m_int);
    check("rdata", cfg.cfg_rdata, m_rdata);
    cfg.cfg_wen = 1'b0;
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg.cfg_wen = 1'b1;
    cfg.cfg_addr = a;
    cfg.cfg_wdata = d;
    step();
  endtask
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    #1;
    m_reset();
    check("rst_int_async", interrupts, 0);
    repeat (n) step();
    rst_n = 1'b1;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int cnt, first, found;
    int pt [$];
    logic [31:0] rd [5];
    cfg.cfg_wen = 1'b0;
    cfg.cfg_addr = 2'd0;
    cfg.cfg_wdata = '0;
    #2;
    irq_in = '1;
    do_reset(3);
    cnt = 0;
    repeat (20) begin step(); if (interrupts != 0) cnt++; end
    check("ffff_masked", cnt, 0);
    irq_in = '0;
    repeat (4) step();
    clk_en = 1'b1;
    wr(1, 1);
    wr(2, 5);
    found = 0;
    for (int t = 0; t < 20; t++) begin
      step();
      if (interrupts[0]) begin found = 1; break; end
    end
    check("midpulse_seen", found, 1);
    do_reset(2);
    for (int a = 0; a < 4; a++) begin
      cfg.cfg_addr = 2'(a);
      step();
      check("rst_read", cfg.cfg_rdata, 0);
    end
    wr(0, 32'h4);
    wr(1, 32'h4);
    irq_in[2] = 1'b1;
    first = -1;
    cnt = 0;
    for (int t = 1; t <= 200; t++) begin
      step();
      if (interrupts != 0) begin
        cnt++;
        if (first < 0) begin first = t; check("edge_val", interrupts, 16'h0004); end
      end
    end
    check("edge_cnt", cnt, 1);
    check("edge_lat", first, 3);
    irq_in = '0;
    repeat (5) step();
    wr(0, 0);
    wr(1, 32'h10);
    irq_in[4] = 1'b1;
    pt = {};
    for (int t = 1; t <= 200; t++) begin step(); if (interrupts[4]) pt.push_back(t); end
    check("lvl_cnt", pt.size(), 4);
    if (pt.size() > 0) check("lvl_first", pt[0], 3);
    for (int k = 1; k < pt.size(); k++) check("lvl_gap", pt[k] - pt[k-1], LR);
    irq_in = '0;
    cnt = 0;
    repeat (100) begin step(); if (interrupts != 0) cnt++; end
    check("lvl_stop", cnt, 0);
    wr(0, 32'h80);
    wr(1, 0);
    irq_in[7] = 1'b1;
    cnt = 0;
    repeat (10) begin step(); if (interrupts != 0) cnt++; end
    wr(1, 32'h80);
    if (interrupts != 0) cnt++;
    repeat (10) begin step(); if (interrupts != 0) cnt++; end
    check("mask_edge_drop", cnt, 0);
    irq_in = '0;
    wr(1, 0);
    repeat (4) step();
    wr(0, 0);
    irq_in[7] = 1'b1;
    repeat (10) step();
    wr(1, 32'h80);
    check("unmask_wr_cycle", interrupts[7], 0);
    step();
    check("unmask_pulse", interrupts[7], 1);
    irq_in = '0;
    wr(1, 0);
    repeat (4) step();
    wr(1, 1);
    clk_en = 1'b1;
    wr(2, 5);
    pt = {};
    for (int t = 1; t <= 40; t++) begin step(); if (interrupts[0]) pt.push_back(t); end
    check("tmr_cnt", pt.size(), 8);
    if (pt.size() > 0) check("tmr_first", pt[0], 5);
    for (int k = 1; k < pt.size(); k++) check("tmr_gap", pt[k] - pt[k-1], 5);
    cfg.cfg_addr = 2'd3;
    for (int k = 0; k < 5; k++) begin step(); rd[k] = cfg.cfg_rdata; end
    for (int k = 0; k < 4; k++) check("cnt_seq", rd[k+1], rd[k] == 1 ? 32'd5 : rd[k] - 1);
    pt = {};
    for (int t = 1; t <= 60; t++) begin
      clk_en = (t % 2) == 1;
      step();
      if (interrupts[0]) pt.push_back(t);
    end
    check("tmr_half_cnt", pt.size() >= 4, 1);
    for (int k = 1; k < pt.size(); k++) check("tmr_half_gap", pt[k] - pt[k-1], 10);
    clk_en = 1'b1;
    wr(2, 0);
    cnt = 0;
    repeat (30) begin step(); if (interrupts[0]) cnt++; end
    check("tmr_off", cnt, 0);
    wr(2, 3);
    found = 0;
    for (int t = 0; t < 10; t++) begin
      if (m_count == 1) begin found = 1; break; end
      step();
    end
    check("sim_found", found, 1);
    wr(2, 3);
    check("sim_pulse", interrupts[0], 1);
    cfg.cfg_addr = 2'd3;
    step();
    check("sim_count", cfg.cfg_rdata, 3);
    wr(0, 1);
    found = 0;
    for (int t = 0; t < 10; t++) begin
      if (m_count == 3) begin found = 1; break; end
      step();
    end
    check("coin_found", found, 1);
    irq_in[0] = 1'b1;
    cnt = 0;
    repeat (5) begin step(); if (interrupts[0]) cnt++; end
    check("coin_single", cnt, 1);
    irq_in = '0;
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(15) == 0) begin
        first = $urandom_range(N - 1);
        irq_in[first] = ~irq_in[first];
      end
      clk_en = $urandom_range(3) != 0;
      cfg.cfg_addr = 2'($urandom_range(3));
      if ($urandom_range(19) == 0) begin
        cfg.cfg_wen = 1'b1;
        cfg.cfg_wdata = cfg.cfg_addr < 2 ? $urandom : 32'($urandom_range(12));
      end
      if ($urandom_range(999) == 0) do_reset(2);
      else step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
